// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end.
//
// Contents:
//   FETCH_ADDR_W / FETCH_DATA_W : default PC and instruction widths
//   NOP_INSTR                   : instruction shown to decode when no entry is valid
//   PC_INCR                     : word-address step between sequential instructions
//   fetch_entry_t               : one prefetch buffer entry {pc, instr}
//   fetch_cnt_w()               : width of a counter that must hold 0..depth
package fetch_pkg;

  localparam int FETCH_ADDR_W = 32;
  localparam int FETCH_DATA_W = 32;

  localparam logic [FETCH_DATA_W-1:0] NOP_INSTR = 32'h0;
  localparam int                      PC_INCR   = 1;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] instr;
  } fetch_entry_t;

  // A counter that reaches exactly `depth` needs one bit more than the pointer.
  function automatic int fetch_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Bus bundle between the fetch queue, the instruction memory and decode.
//
// Signals:
//   imem_req / imem_addr      : read request and word address (fetch queue drives)
//   imem_gnt                  : memory accepts the request this cycle
//   imem_rvalid / imem_rdata  : in-order read response, latency >= 1
//   if_valid / if_instr / if_pc : head instruction presented to decode
//   if_ready                  : decode consumes the head this cycle
//
// Modports:
//   master : the fetch queue
//   slave  : the environment (instruction memory plus decode stage)
interface inst_fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch entries with flush.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the tail (ignored during flush)
//   pop        : drop the head entry (ignored during flush or when empty)
//   flush      : empty the buffer at this edge; overrides push and pop
//   push_data  : entry to write
//   head       : entry at the head, combinational read (undefined when count = 0)
//   count      : number of stored entries, 0..DEPTH
//
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 push_data,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fetch_cnt_w(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             empty;
  logic             full;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only read once count says it was written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // No bypass: a word pushed into an empty buffer becomes the head next cycle.
  assign head = mem[rd_ptr];

  // The upstream credit scheme reserves a slot for every request in flight,
  // so a push can never find the buffer full.
  a_no_push_when_full: assert property (
    @(posedge clk) disable iff (!rst_n) !(do_push && full)
  );

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end feeding the IF/ID register.
//
// Issues sequential word-address reads to a variable-latency instruction
// memory, buffers the returned words with their PC, and presents them to
// decode. A redirect from the pipeline flushes the buffer, restarts fetch at
// redirect_pc and squashes responses that are still in flight.
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   bus (master)   : imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata toward
//                    memory; if_valid/if_ready/if_instr/if_pc toward decode
//   redirect_valid : taken branch/jump this cycle; flush and restart
//   redirect_pc    : new fetch address
//   occupancy      : entries currently stored in the prefetch buffer
//
// Handshakes: a transfer happens on a clock edge where the producer's valid
// (imem_req, if_valid) and the consumer's accept (imem_gnt, if_ready) are both
// high. While imem_req is held without imem_gnt, imem_addr stays stable except
// in a redirect cycle, where imem_req drops and the address may change.
// if_valid does not depend on if_ready.
//
// Credits: a request is only issued while stored + in-flight < DEPTH, so every
// response is guaranteed a buffer slot. After a redirect, `discard` counts the
// stale responses still to arrive; they are dropped without touching resp_pc.
module inst_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inst_fetch_queue_if.master     bus,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int                CNT_W      = fetch_cnt_w(DEPTH);
  localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  discard;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  outstanding_after_rsp;
  logic [CNT_W:0]    credits_used;
  logic              issue;
  logic              push;
  logic              pop;
  entry_t            push_entry;
  entry_t            head_entry;

  // ---------------------------------------------------------------- issue
  assign credits_used = {1'b0, count} + {1'b0, outstanding};

  // Gating with rst_n keeps the request low for the whole reset pulse, not
  // just until the counters clear.
  assign bus.imem_req  = rst_n & (credits_used < CREDIT_MAX) & ~redirect_valid;
  assign bus.imem_addr = fetch_pc;
  assign issue         = bus.imem_req & bus.imem_gnt;

  // In-flight count once this cycle's response (if any) has retired.
  assign outstanding_after_rsp = outstanding - CNT_W'(bus.imem_rvalid);

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= '0;
      resp_pc     <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path.
      // A response arriving in this very cycle is dropped outright.
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      outstanding <= outstanding_after_rsp;
      discard     <= outstanding_after_rsp;
    end else begin
      if (issue) fetch_pc <= fetch_pc + ADDR_W'(PC_INCR);
      outstanding <= outstanding_after_rsp + CNT_W'(issue);
      if (bus.imem_rvalid) begin
        if (discard != '0) discard <= discard - CNT_W'(1);
        else               resp_pc <= resp_pc + ADDR_W'(PC_INCR);
      end
    end
  end

  // ---------------------------------------------------------------- buffer
  assign push             = bus.imem_rvalid & ~redirect_valid & (discard == '0);
  assign pop              = bus.if_valid & bus.if_ready & ~redirect_valid;
  assign push_entry.pc    = resp_pc;
  assign push_entry.instr = bus.imem_rdata;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_entry),
    .head      (head_entry),
    .count     (count)
  );

  // ---------------------------------------------------------------- decode side
  // An invalid slot shows a NOP with PC 0 so the IF/ID register never latches
  // stale buffer contents.
  assign bus.if_valid = (count != '0);
  assign bus.if_instr = bus.if_valid ? head_entry.instr : DATA_W'(NOP_INSTR);
  assign bus.if_pc    = bus.if_valid ? head_entry.pc    : '0;
  assign occupancy    = count;

  // A response with nothing in flight means the memory broke the protocol.
  a_rvalid_has_request: assert property (
    @(posedge clk) disable iff (!rst_n) bus.imem_rvalid |-> (outstanding != '0)
  );

  a_credits_bounded: assert property (
    @(posedge clk) disable iff (!rst_n) credits_used <= CREDIT_MAX
  );

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
Instruction fetch front-end that sits directly upstream of the CPU pipeline's IF/ID register. It issues word-addressed reads to a variable-latency instruction memory, buffers returned words with their PC in a small prefetch FIFO, and presents them to decode with a valid/ready handshake. Branch and jump redirects from the pipeline flush the queue and squash in-flight responses.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of 2, >=2); also caps total credits (stored + in-flight)
ADDR_W, 32, PC / instruction-memory address width (word address, PC+1 per instruction)
DATA_W, 32, instruction width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  read request to instruction memory
imem_addr  output  ADDR_W  word address of request (= fetch_pc)
imem_gnt  input  1  memory accepts request this cycle (req & gnt = issue)
imem_rvalid  input  1  read data valid; responses return in issue order, latency >=1
imem_rdata  input  DATA_W  read data
redirect_valid  input  1  pipeline taken branch/jump; flush and restart
redirect_pc  input  ADDR_W  new fetch address
if_valid  output  1  head entry available to decode
if_ready  input  1  decode consumes head this cycle
if_instr  output  DATA_W  head instruction; 0 (bubble/NOP) when if_valid=0
if_pc  output  ADDR_W  PC of head instruction; 0 when if_valid=0
occupancy  output  $clog2(DEPTH)+1  entries currently stored

Behaviour:
- Reset (rst_n=0, asynchronous): fetch_pc=0, resp_pc=0, FIFO empty, occupancy=0, outstanding=0, discard=0; if_valid=0, if_instr=0, if_pc=0, imem_req=0 while rst_n low.
- Issue: imem_req = (occupancy + outstanding < DEPTH) & !redirect_valid; imem_addr = fetch_pc. On req & gnt: fetch_pc += 1 (wraps mod 2^ADDR_W), outstanding += 1. First request asserts in first cycle after reset release, address 0.
- Address may change without gnt only in a redirect cycle; otherwise imem_addr is stable while req is held.
- Response: on rvalid, outstanding -= 1. If discard > 0: discard -= 1, data dropped. Else push {resp_pc, imem_rdata}, resp_pc += 1.
- Credit rule guarantees no push when full; a push into a full FIFO is an assertion failure, not a handled case.
- Output: if_valid = occupancy != 0; head data combinational from FIFO. Pop on if_valid & if_ready. Simultaneous push and pop: occupancy unchanged; push into empty FIFO is visible next cycle (no bypass, latency issue→if_valid = memory latency + 1 cycle).
- Redirect (redirect_valid=1), effective at that clock edge, overrides all else: FIFO cleared (a same-cycle pop is ignored), fetch_pc = resp_pc = redirect_pc, discard = outstanding - rvalid, outstanding = outstanding - rvalid, no issue that cycle; rvalid in that cycle is dropped. Back-to-back redirects: each recomputes discard the same way; last one wins.
- Counters sized $clog2(DEPTH)+1; outstanding, discard never exceed DEPTH.
- No state machine beyond counters; behaviour fully described by fetch_pc, resp_pc, outstanding, discard, FIFO pointers.

Decomposition:
- Shared package fetch_pkg: NOP_INSTR (32'h0), fetch_entry_t {pc, instr}, PC_INCR (1).
- One sub-module natural: fetch_fifo (synchronous FIFO of fetch_entry_t, DEPTH entries, push/pop/flush, count, combinational head).

Test Plan:
- Zero-wait memory (gnt=1, rvalid 1 cycle later), if_ready=1 -> if_pc streams 0,1,2,3... one per cycle after 2-cycle startup; if_instr matches memory word at each address.
- if_ready=0 for 10 cycles, gnt=1 -> exactly DEPTH=4 requests issued (addrs 0-3), occupancy=4, imem_req=0; after single pop, one new request addr 4.
- 3-cycle response latency, 2 in-flight, redirect_pc=0x40 -> both stale responses dropped, next if_valid shows if_pc=0x40, no PC 2/3 ever visible.
- Redirect in same cycle as rvalid and if_ready with occupancy=2 -> FIFO empty next cycle, stale word dropped, discard = outstanding-1, imem_addr=redirect_pc following cycle.
- gnt held low 5 cycles -> imem_req high, imem_addr=fetch_pc stable all 5 cycles, no fetch_pc increment.
- Assert rst_n low mid-stream with occupancy=3, outstanding=1 -> immediately if_valid=0, if_instr=0, imem_req=0; after release first request addr 0.
